opb_snapshot_ctrl: RTL

OPB_SNAPSHOT_CTRL -- requirements
Module: opb_snapshot_ctrl

---
 rtl/opb_snapshot_ctrl.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/opb_snapshot_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : opb_snapshot_ctrl
// Brief   : OPB slave that arms on a register write, snapshots four user
//           words on a trigger and exposes them through a 256-byte window.
// Option  : define SNAPSHOT_TIMESTAMP_EN to stamp captures with a cycle count.
// Revision: 1.0 - initial release
// ============================================================================
module opb_snapshot_ctrl #(
    parameter logic [31:0] C_BASEADDR   = 32'h01080200,
    parameter logic [31:0] C_HIGHADDR   = 32'h010802FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32
) (
    input  logic                        OPB_Clk,
    input  logic                        OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
    input  logic                        OPB_RNW,
    input  logic                        OPB_select,
    input  logic                        OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
    output logic                        Sl_xferAck,
    output logic                        Sl_errAck,
    output logic                        Sl_retry,
    output logic                        Sl_toutSup,
    input  logic [31:0]                 user_data0,
    input  logic [31:0]                 user_data1,
    input  logic [31:0]                 user_data2,
    input  logic [31:0]                 user_data3,
    input  logic                        user_trig,
    output logic                        snap_busy
);

    // Word indices within the register window
    localparam logic [5:0] c_word_ctrl   = 6'd0;
    localparam logic [5:0] c_word_status = 6'd1;
    localparam logic [5:0] c_word_data0  = 6'd2;
    localparam logic [5:0] c_word_data1  = 6'd3;
    localparam logic [5:0] c_word_data2  = 6'd4;
    localparam logic [5:0] c_word_data3  = 6'd5;
    localparam logic [5:0] c_word_tstamp = 6'd6;

    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,
        BUS_ACK  = 2'd1,
        BUS_WAIT = 2'd2
    } bus_state_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } cap_state_t;

    bus_state_t  r_bus_state;
    cap_state_t  r_cap_state;

    logic        r_xfer_ack;
    logic [31:0] r_rd_data;
    logic [5:0]  r_word;
    logic        r_rnw;

    logic        r_busy;
    logic        r_valid;
    logic [15:0] r_count;
    logic [31:0] r_data0;
    logic [31:0] r_data1;
    logic [31:0] r_data2;
    logic [31:0] r_data3;

    logic        w_hit;
    logic [5:0]  w_word;
    logic [31:0] w_wdata;
    logic [31:0] w_rd_mux;
    logic [31:0] w_tstamp;
    logic        w_ctrl_wr;
    logic        w_arm;
    logic        w_abort;
    logic        w_capture;
    logic        w_unused;

    // ------------------------------------------------------------------------
    // Address decode and write strobes
    // ------------------------------------------------------------------------
    assign w_hit   = OPB_select
                   && (OPB_ABus >= C_BASEADDR)
                   && (OPB_ABus <= C_HIGHADDR);
    assign w_word  = OPB_ABus[C_OPB_AWIDTH-8:C_OPB_AWIDTH-3];
    assign w_wdata = OPB_DBus;

    // Writes land on the edge that closes the acknowledge cycle
    assign w_ctrl_wr = (r_bus_state == BUS_ACK) && !r_rnw && OPB_BE[0]
                     && (r_word == c_word_ctrl);
    assign w_arm     = w_ctrl_wr && w_wdata[31];
    assign w_abort   = w_ctrl_wr && w_wdata[30];
    assign w_capture = (r_cap_state == ARMED) && user_trig && !w_abort;

    assign w_unused = ^{OPB_seqAddr, OPB_BE[1:C_OPB_DWIDTH/8-1],
                        OPB_DBus[2:C_OPB_DWIDTH-1]};

    // ------------------------------------------------------------------------
    // Read multiplexer
    // ------------------------------------------------------------------------
    always_comb begin
        w_rd_mux = '0;
        case (w_word)
            c_word_status: w_rd_mux = {r_valid, r_busy, 14'd0, r_count};
            c_word_data0:  w_rd_mux = r_data0;
            c_word_data1:  w_rd_mux = r_data1;
            c_word_data2:  w_rd_mux = r_data2;
            c_word_data3:  w_rd_mux = r_data3;
            c_word_tstamp: w_rd_mux = w_tstamp;
            default:       w_rd_mux = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // OPB handshake: one registered ack, then park until select drops
    // ------------------------------------------------------------------------
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            r_bus_state <= BUS_IDLE;
            r_xfer_ack  <= 1'b0;
            r_rd_data   <= '0;
            r_word      <= '0;
            r_rnw       <= 1'b1;
        end else begin
            r_xfer_ack <= 1'b0;
            r_rd_data  <= '0;
            case (r_bus_state)
                BUS_IDLE: begin
                    if (w_hit) begin
                        r_bus_state <= BUS_ACK;
                        r_xfer_ack  <= 1'b1;
                        r_rd_data   <= OPB_RNW ? w_rd_mux : 32'd0;
                        r_word      <= w_word;
                        r_rnw       <= OPB_RNW;
                    end
                end
                BUS_ACK: begin
                    r_bus_state <= BUS_WAIT;
                end
                BUS_WAIT: begin
                    if (!OPB_select) begin
                        r_bus_state <= BUS_IDLE;
                    end
                end
                default: begin
                    r_bus_state <= BUS_IDLE;
                end
            endcase
        end
    end

    assign Sl_DBus    = r_rd_data;
    assign Sl_xferAck = r_xfer_ack;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    // ------------------------------------------------------------------------
    // Capture sequencer; abort overrides every other transition
    // ------------------------------------------------------------------------
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            r_cap_state <= IDLE;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
            r_count     <= '0;
            r_data0     <= '0;
            r_data1     <= '0;
            r_data2     <= '0;
            r_data3     <= '0;
        end else if (w_abort) begin
            r_cap_state <= IDLE;
            r_busy      <= 1'b0;
        end else begin
            case (r_cap_state)
                IDLE, DONE: begin
                    if (w_arm) begin
                        r_cap_state <= ARMED;
                        r_busy      <= 1'b1;
                        r_valid     <= 1'b0;
                    end
                end
                ARMED: begin
                    if (w_capture) begin
                        r_cap_state <= CAPTURE;
                        r_data0     <= user_data0;
                        r_data1     <= user_data1;
                        r_data2     <= user_data2;
                        r_data3     <= user_data3;
                    end
                end
                CAPTURE: begin
                    r_cap_state <= DONE;
                    r_busy      <= 1'b0;
                    r_valid     <= 1'b1;
                    r_count     <= r_count + 16'd1;
                end
                default: begin
                    r_cap_state <= IDLE;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign snap_busy = r_busy;

    // ------------------------------------------------------------------------
    // Optional capture timestamp
    // ------------------------------------------------------------------------
`ifdef SNAPSHOT_TIMESTAMP_EN
    logic [31:0] r_cycle;
    logic [31:0] r_tstamp;

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            r_cycle  <= '0;
            r_tstamp <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_capture) begin
                r_tstamp <= r_cycle;
            end
        end
    end

    assign w_tstamp = r_tstamp;
`else
    assign w_tstamp = '0;
`endif

endmodule
`default_nettype wire
